cpu_out_uart_tx: RTL
====================

Name: cpu_out_uart_tx

Overview:
- Downstream consumer of the 4-bit CPU output register.
- Watches the CPU's 4-bit output value and queues each new value in a small FIFO.
- Transmits each queued value as one ASCII hex character over an 8N1 UART line.
- Gives the CPU a host-visible output channel without changing CPU timing; no handshake back to the CPU.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥2.
- FIFO_DEPTH, 4, character FIFO entries; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  4  CPU output value, sampled every clk edge.
- clear_overflow  input  1  synchronous; clears overflow when high.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued characters.
- overflow  output  1  sticky flag; set when a change is dropped because the FIFO is full.

Behaviour:
- Reset (async, active-high):
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - Internal last-value register prev=0; FSM=IDLE; bit and baud counters=0.
- Change detect:
  - On each edge, if data_in != prev: push ASCII(data_in) and set prev<=data_in.
  - Repeated identical values never push.
  - A change from the reset value 0 to 0 is not a change.
- ASCII mapping:
  - 0–9 → 0x30–0x39.
  - A–F → 0x41–0x46 (uppercase).
- FIFO push/pop rules:
  - Push when full: character dropped, overflow<=1, prev still updates.
  - Pop happens only in IDLE when fifo_count>0.
  - Push and pop on the same edge: both take effect, count unchanged. This applies when full, since the pop frees a slot and no overflow is raised.
  - Pop on empty: never occurs.
- overflow:
  - Set on a dropped push; cleared by clear_overflow.
  - If a set and a clear occur on the same edge, set wins.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: tx=1. If fifo_count>0, pop head into shift register and go to START on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency:
  - data_in changes before edge N → pushed at edge N.
  - Popped at edge N+1 → tx falls at edge N+1.
- Frame spacing:
  - Minimum 1 idle cycle between frames.
  - Back-to-back start-to-start spacing = 10*CLKS_PER_BIT + 1 cycles.
- tx is registered; glitch-free.
- busy is asserted from the edge entering START until the edge returning to IDLE.
- Reset mid-frame:
  - tx returns high immediately (asynchronously).
  - Partial frame is abandoned; FIFO contents are discarded.
- Input timing: data_in comes from the CPU's clk domain. No synchronizer is required.

Optional Feature:
- Macro: CPU_OUT_UART_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP; tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1, 11 bits.
  - Start-to-start spacing becomes 11*CLKS_PER_BIT + 1.
- When undefined: 8N1 exactly as above; the PARITY state does not exist.

Test Plan:
1. Reset, data_in held 0 for 500 cycles → tx stays 1, busy=0, fifo_count=0, no frame.
2. data_in 0→0xA at edge N (CLKS_PER_BIT=16) → tx falls at N+1; bits LSB-first 1,0,0,0,0,0,1,0 (0x41); stop high; busy drops 160 cycles after N+1.
3. data_in 0→0xA, then 0x7 three cycles later, then held → frames 0x41 then 0x37; second start bit 161 cycles after first; 0x7 held produces no third frame.
4. Six distinct changes on consecutive edges (FIFO_DEPTH=4) → exactly 5 frames sent in order, 6th dropped, overflow=1, fifo_count peaks at 4; then pulse clear_overflow → overflow=0.
5. Assert reset at cycle 40 of a frame → tx=1 within the same cycle, busy=0, fifo_count=0, overflow=0; after release, a new change transmits a complete clean frame.
6. With CPU_OUT_UART_PARITY_EN: send 0xA, then 0x7 → parity bit 0 for 0x41, 1 for 0x37; start-to-start spacing 177 cycles.

Source files
------------

// File: rtl/cpu_out_uart_tx.sv
// cpu_out_uart_tx: watches the CPU 4-bit output register, queues each new
// value as an ASCII hex character and sends it on an 8N1 UART line.
// Optional: define CPU_OUT_UART_PARITY_EN for 8E1 framing (even parity bit).
module cpu_out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    data_in,
    input  logic                          clear_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef CPU_OUT_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [3:0]      prev_q, prev_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef CPU_OUT_UART_PARITY_EN
    logic            par_q, par_d;
`endif
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            change, full, push, pop, drop, last;
    logic [7:0]      ascii;

    // Change detect, FIFO bookkeeping and the overflow flag.
    always_comb begin
        change  = (data_in != prev_q);
        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = (state_q == IDLE) && (count_q != '0);
        // A pop on the same edge frees a slot, so a full FIFO still accepts.
        push    = change && (!full || pop);
        drop    = change && full && !pop;
        ascii   = (data_in < 4'd10) ? {4'h3, data_in} : (8'h37 + {4'h0, data_in});
        prev_d  = data_in;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Set wins over a simultaneous clear.
        ovf_d = drop | (ovf_q & ~clear_overflow);
    end

    // Frame sequencer: each state holds tx for CLKS_PER_BIT cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef CPU_OUT_UART_PARITY_EN
        par_d   = par_q;
`endif
        last    = (baud_q == BW'(CLKS_PER_BIT - 1));
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (pop) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
`ifdef CPU_OUT_UART_PARITY_EN
                    par_d   = ^mem_q[rd_ptr_q];
`endif
                end
            end
            START: if (last) begin
                state_d = DATA;
                baud_d  = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (last) begin
                baud_d = '0;
                if (bit_q == 3'd7) begin
`ifdef CPU_OUT_UART_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                end
            end
`ifdef CPU_OUT_UART_PARITY_EN
            PARITY: if (last) begin
                state_d = STOP;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (last) begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset abandons any frame and empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef CPU_OUT_UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef CPU_OUT_UART_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Character storage; stale entries are ignored via the reset pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ascii;
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule
